// File: rtl/dog_pkg.sv
// Shared types and widths for the DoG result writer: FSM encoding, word/address
// widths and the tagged FIFO entry layout.
package dog_pkg;

    localparam int WORD_W  = 24;
    localparam int ADDR_W  = 21;
    localparam int ENTRY_W = WORD_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OCT0  = 3'd1,
        ST_OCT1  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } dog_state_t;

    // diff0 lands in the low byte of the memory word
    function automatic logic [WORD_W-1:0] pack_word(input logic [7:0] d0,
                                                     input logic [7:0] d1,
                                                     input logic [7:0] d2);
        return {d2, d1, d0};
    endfunction

endpackage

// File: rtl/dog_wr_fifo.sv
// Word buffer for dog_result_writer: register-array FIFO whose head entry is
// presented directly on o_data; push and pop may coincide, including when full.
module dog_wr_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // Storage is cleared on reset so the head reads as zero while empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/dog_result_writer.sv
// Streams packed DoG pixel words for two octaves into memory through a tagged FIFO.
// Optional feature: define DOG_WR_OVF_CNT_EN to add the 16-bit saturating ovf_cnt output.
//
// state    | meaning
// ST_IDLE  | waiting for the first sample of a frame
// ST_OCT0  | octave 0 streaming, words go to BASE0 + n
// ST_OCT1  | octave 1 streaming, new words go to BASE1 + n
// ST_FLUSH | both octaves finished, draining queued words
// ST_DONE  | all words written, inputs ignored until reset
module dog_result_writer
    import dog_pkg::*;
#(
    parameter int                FIFO_DEPTH = 16,
    parameter logic [ADDR_W-1:0] BASE0      = 21'h000000,
    parameter logic [ADDR_W-1:0] BASE1      = 21'h100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [7:0]   diff0,
    input  logic signed [7:0]   diff1,
    input  logic signed [7:0]   diff2,
    input  logic                in_en,
    input  logic                complete1,
    input  logic                complete2,
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [WORD_W-1:0]   wr_data,
    output logic                done,
    output logic                drop
`ifdef DOG_WR_OVF_CNT_EN
    ,
    output logic [15:0]         ovf_cnt
`endif
);

    dog_state_t         r_state, w_state_nxt;
    logic               r_c1_d, r_c2_d;
    logic [ADDR_W-1:0]  r_ptr0, r_ptr1;
    logic               w_c1_rise, w_c2_rise;
    logic               w_live, w_push, w_pop, w_tag;
    logic               w_full, w_empty;
    logic [ENTRY_W-1:0] w_head;

    assign w_c1_rise = complete1 & ~r_c1_d;
    assign w_c2_rise = complete2 & ~r_c2_d;
    assign w_live    = (r_state != ST_DONE);
    assign w_pop     = wr_valid & wr_ready;
    // A full buffer still takes a sample when the head leaves in the same cycle
    assign w_push    = in_en & w_live & (~w_full | w_pop);
    assign drop      = in_en & w_live & w_full & ~w_pop;
    assign w_tag     = (r_state == ST_OCT1) || (r_state == ST_FLUSH) ||
                       ((r_state == ST_OCT0) && w_c1_rise);

    dog_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({w_tag, pack_word(diff0, diff1, diff2)}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_c1_d  <= 1'b0;
            r_c2_d  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_c1_d  <= complete1;
            r_c2_d  <= complete2;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (in_en) w_state_nxt = ST_OCT0;
            ST_OCT0: begin
                if (w_c1_rise && w_c2_rise) w_state_nxt = ST_FLUSH;
                else if (w_c1_rise)         w_state_nxt = ST_OCT1;
            end
            ST_OCT1:  if (w_c2_rise) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (w_empty && !w_push) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_DONE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_valid = ~w_empty && (r_state != ST_IDLE) && (r_state != ST_DONE);
        wr_data  = w_head[WORD_W-1:0];
        wr_addr  = '0;
        if (wr_valid) wr_addr = w_head[ENTRY_W-1] ? r_ptr1 : r_ptr0;
        done     = (r_state == ST_DONE);
    end

    // Each octave owns its pointer; it advances only on a completed handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr0 <= BASE0;
            r_ptr1 <= BASE1;
        end else if (w_pop) begin
            if (w_head[ENTRY_W-1]) r_ptr1 <= r_ptr1 + 1'b1;
            else                   r_ptr0 <= r_ptr0 + 1'b1;
        end
    end

`ifdef DOG_WR_OVF_CNT_EN
    logic [15:0] r_ovf_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                             r_ovf_cnt <= '0;
        else if (drop && r_ovf_cnt != 16'hFFFF) r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end

    assign ovf_cnt = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_dog_result_writer.sv
// Directed bench for dog_result_writer: a vector table for the basic stream plus
// hand-written sequences for overflow, octave switch, flush/done and mid-frame reset.
module tb_dog_result_writer;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [7:0]  diff0 = '0, diff1 = '0, diff2 = '0;
    logic               in_en = 1'b0;
    logic               complete1 = 1'b0, complete2 = 1'b0;
    logic               wr_valid;
    logic               wr_ready = 1'b0;
    logic [20:0]        wr_addr;
    logic [23:0]        wr_data;
    logic               done;
    logic               drop;
`ifdef DOG_WR_OVF_CNT_EN
    logic [15:0]        ovf_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dog_result_writer dut (
        .clk       (clk),
        .rst       (rst),
        .diff0     (diff0),
        .diff1     (diff1),
        .diff2     (diff2),
        .in_en     (in_en),
        .complete1 (complete1),
        .complete2 (complete2),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .done      (done),
        .drop      (drop)
`ifdef DOG_WR_OVF_CNT_EN
        ,
        .ovf_cnt   (ovf_cnt)
`endif
    );

    typedef struct {
        logic        en;
        logic [7:0]  d0, d1, d2;
        logic        rdy;
        logic        exp_v;
        logic [20:0] exp_a;
        logic [23:0] exp_d;
        logic        exp_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic en, logic [7:0] d0, logic [7:0] d1, logic [7:0] d2,
                                logic rdy, logic v, logic [20:0] a, logic [23:0] d,
                                logic dr);
        vec_t x;
        x.en = en; x.d0 = d0; x.d1 = d1; x.d2 = d2; x.rdy = rdy;
        x.exp_v = v; x.exp_a = a; x.exp_d = d; x.exp_drop = dr;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic rdy);
        in_en = en; diff0 = d0; diff1 = d1; diff2 = d2; wr_ready = rdy;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        complete1 = 1'b0;
        complete2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int drops;
        int hs;
        int cyc;
        logic [23:0] exp_w;

        // basic stream, stall and second burst
        vecs.push_back(mk(1, 8'h01, 8'hFE, 8'h03, 1, 0, 21'd0, 24'h0,      0));
        vecs.push_back(mk(1, 8'h01, 8'hFE, 8'h03, 1, 1, 21'd0, 24'h03FE01, 0));
        vecs.push_back(mk(1, 8'h01, 8'hFE, 8'h03, 1, 1, 21'd1, 24'h03FE01, 0));
        vecs.push_back(mk(1, 8'h01, 8'hFE, 8'h03, 1, 1, 21'd2, 24'h03FE01, 0));
        vecs.push_back(mk(1, 8'h01, 8'hFE, 8'h03, 1, 1, 21'd3, 24'h03FE01, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 1, 1, 21'd4, 24'h03FE01, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 1, 0, 21'd0, 24'h0,      0));
        vecs.push_back(mk(1, 8'h80, 8'h7F, 8'h00, 1, 0, 21'd0, 24'h0,      0));
        vecs.push_back(mk(1, 8'hAA, 8'h55, 8'h11, 0, 1, 21'd5, 24'h007F80, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 0, 1, 21'd5, 24'h007F80, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 1, 1, 21'd5, 24'h007F80, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 1, 1, 21'd6, 24'h1155AA, 0));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 1, 0, 21'd0, 24'h0,      0));

        #3;
        check("reset wr_valid", 32'(wr_valid), 32'd0);
        check("reset done",     32'(done),     32'd0);
        check("reset drop",     32'(drop),     32'd0);
        check("reset wr_addr",  32'(wr_addr),  32'd0);
        check("reset wr_data",  32'(wr_data),  32'd0);
        do_reset();

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].rdy);
            @(negedge clk);
            check($sformatf("vec%0d wr_valid", i), 32'(wr_valid), 32'(vecs[i].exp_v));
            check($sformatf("vec%0d drop", i),     32'(drop),     32'(vecs[i].exp_drop));
            if (vecs[i].exp_v) begin
                check($sformatf("vec%0d wr_addr", i), 32'(wr_addr), 32'(vecs[i].exp_a));
                check($sformatf("vec%0d wr_data", i), 32'(wr_data), 32'(vecs[i].exp_d));
            end
            next_cycle();
        end

        // overflow: 20 samples into a stalled port
        do_reset();
        drops = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(i), ~8'(i), 8'h5A, 1'b0);
            @(negedge clk);
            check($sformatf("ovf%0d drop", i), 32'(drop), 32'(i >= 16));
            check($sformatf("ovf%0d wr_valid", i), 32'(wr_valid), 32'(i >= 1));
            if (i >= 1) check($sformatf("ovf%0d hold", i), 32'(wr_data), 32'h5AFF00);
            if (drop) drops++;
            next_cycle();
        end
        check("ovf drop count", 32'(drops), 32'd4);
`ifdef DOG_WR_OVF_CNT_EN
        check("ovf_cnt", 32'(ovf_cnt), 32'd4);
`endif
        // push and pop together while full
        drive(1'b1, 8'd20, ~8'd20, 8'h5A, 1'b1);
        @(negedge clk);
        check("full push+pop drop", 32'(drop), 32'd0);
        check("full push+pop data", 32'(wr_data), 32'h5AFF00);
        next_cycle();
        for (int k = 1; k <= 16; k++) begin
            automatic int idx = (k == 16) ? 20 : k;
            drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
            @(negedge clk);
            exp_w = {8'h5A, ~8'(idx), 8'(idx)};
            check($sformatf("drain%0d valid", k), 32'(wr_valid), 32'd1);
            check($sformatf("drain%0d addr", k),  32'(wr_addr),  32'(k));
            check($sformatf("drain%0d data", k),  32'(wr_data),  32'(exp_w));
            next_cycle();
        end
        @(negedge clk);
        check("drain empty", 32'(wr_valid), 32'd0);
        next_cycle();

        // octave switch with 3 words queued; coincident sample goes to octave 1
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h10 + i), 8'h00, 8'h00, 1'b0);
            next_cycle();
        end
        complete1 = 1'b1;
        drive(1'b1, 8'h99, 8'h00, 8'h00, 1'b0);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
            @(negedge clk);
            check($sformatf("oct k%0d valid", k), 32'(wr_valid), 32'd1);
            check($sformatf("oct k%0d addr", k), 32'(wr_addr),
                  (k < 3) ? 32'(k) : 32'h100000);
            check($sformatf("oct k%0d data", k), 32'(wr_data),
                  (k < 3) ? 32'(8'h10 + k) : 32'h000099);
            next_cycle();
        end

        // flush: 6 octave-1 words drain with toggling ready
        for (int j = 0; j < 6; j++) begin
            drive(1'b1, 8'(j * 3), 8'h12, 8'h34, 1'b0);
            next_cycle();
        end
        complete2 = 1'b1;
        hs = 0;
        cyc = 0;
        while (cyc < 40) begin
            drive(1'b0, 8'h00, 8'h00, 8'h00, 1'(cyc % 2));
            @(negedge clk);
            if (hs < 6) begin
                check($sformatf("flush c%0d done", cyc), 32'(done), 32'd0);
                check($sformatf("flush c%0d valid", cyc), 32'(wr_valid), 32'd1);
                check($sformatf("flush c%0d addr", cyc), 32'(wr_addr), 32'h100001 + 32'(hs));
                check($sformatf("flush c%0d data", cyc), 32'(wr_data),
                      32'({8'h34, 8'h12, 8'(hs * 3)}));
                if (wr_ready && wr_valid) hs++;
            end else if (done) begin
                check("done valid", 32'(wr_valid), 32'd0);
                break;
            end
            next_cycle();
            cyc++;
        end
        check("done reached", 32'(done), 32'd1);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h77, 8'h77, 8'h77, 1'b1);
            @(negedge clk);
            check($sformatf("done%0d ignore valid", i), 32'(wr_valid), 32'd0);
            check($sformatf("done%0d ignore drop", i),  32'(drop),     32'd0);
            check($sformatf("done%0d held", i),         32'(done),     32'd1);
            next_cycle();
        end

        // reset with 8 words queued
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(8'h40 + i), 8'h00, 8'h00, 1'b0);
            next_cycle();
        end
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        #2;
        check("pre-reset valid", 32'(wr_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("mid reset valid", 32'(wr_valid), 32'd0);
        check("mid reset addr",  32'(wr_addr),  32'd0);
        check("mid reset data",  32'(wr_data),  32'd0);
        check("mid reset done",  32'(done),     32'd0);
        next_cycle();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
            @(negedge clk);
            check($sformatf("post reset%0d valid", i), 32'(wr_valid), 32'd0);
            next_cycle();
        end
        drive(1'b1, 8'h5C, 8'hC5, 8'h01, 1'b1);
        next_cycle();
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        check("restart valid", 32'(wr_valid), 32'd1);
        check("restart addr",  32'(wr_addr),  32'd0);
        check("restart data",  32'(wr_data),  32'h01C55C);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dog_result_writer.md
DOG_RESULT_WRITER -- requirements
Module: dog_result_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, SHALL set the word-buffer entries (power of two, at least 4).
REQ-002 Parameter BASE0, default 21'h000000, SHALL set the octave-0 write base address.
REQ-003 Parameter BASE1, default 21'h100000, SHALL set the octave-1 write base address.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  SHALL be the single rising-edge clock.
REQ-006 rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 diff0, diff1, diff2  in  8 each, signed  SHALL carry the three DoG layers for one pixel.
REQ-008 in_en  in  1  SHALL qualify diff0..2 in the same cycle.
REQ-009 complete1  in  1  SHALL be a level signal meaning octave 0 is finished and octave 1 is streaming.
REQ-010 complete2  in  1  SHALL be a level signal meaning octave 1 is finished.
REQ-011 wr_valid  out  1, wr_ready  in  1, wr_addr  out  21, wr_data  out  24  SHALL form the memory write port.
REQ-012 done  out  1  SHALL be asserted when both octaves have been written.
REQ-013 drop  out  1  SHALL pulse for one cycle when a sample is lost.

Function
REQ-014 A sample SHALL be accepted on each cycle with in_en=1 while the buffer is not full, packed as {diff2,diff1,diff0} with diff0 in bits [7:0].
REQ-015 The buffer SHALL be a FIFO with registered output, and wr_data SHALL equal the head entry.
REQ-016 wr_valid SHALL be high whenever the FIFO is non-empty and state is not IDLE or DONE.
REQ-017 A word SHALL transfer on a cycle where wr_valid and wr_ready are both 1; wr_valid, wr_addr and wr_data SHALL hold stable while wr_ready=0.
REQ-018 Latency SHALL be 1 cycle: a sample accepted into an empty FIFO in cycle N SHALL present wr_valid=1 in cycle N+1.
REQ-019 A simultaneous push and pop SHALL leave the occupancy unchanged and SHALL be allowed when the FIFO is full.
REQ-020 When in_en=1 with the FIFO full and no pop in that cycle, the sample SHALL be discarded, drop SHALL pulse, and the address SHALL NOT advance.
REQ-021 The state machine SHALL have the states IDLE, OCT0, OCT1, FLUSH and DONE.
REQ-022 IDLE SHALL transition to OCT0 on the first in_en=1, loading wr_addr=BASE0.
REQ-023 OCT0 SHALL transition to OCT1 on the rising edge of complete1, after which written words SHALL take addresses from BASE1.
REQ-024 Words already queued in OCT0 SHALL keep their octave-0 addresses, so each FIFO entry SHALL store a 1-bit octave tag.
REQ-025 OCT1 SHALL transition to FLUSH on the rising edge of complete2, and FLUSH SHALL transition to DONE when the FIFO is empty.
REQ-026 In DONE, done SHALL be 1 and in_en SHALL be ignored; the block SHALL stay in DONE until reset.
REQ-027 There SHALL be one 21-bit write pointer per octave, each incremented by 1 per transferred word and wrapping modulo 2^21.
REQ-028 If complete1 and complete2 rise in the same cycle while in OCT0, the block SHALL go directly to FLUSH.
REQ-029 An in_en=1 arriving in the same cycle as the rising edge of complete1 SHALL be tagged octave 1.

Reset
REQ-030 While rst=0, the FIFO SHALL be empty, state SHALL be IDLE, both pointers SHALL equal their bases, and wr_valid, done and drop SHALL be 0.
REQ-031 wr_addr and wr_data SHALL reset to 0.
REQ-032 Reset asserted mid-transfer SHALL abandon all queued words with no further wr_valid.

Configuration
REQ-033 With DOG_WR_OVF_CNT_EN defined, the block SHALL add an output ovf_cnt (16 bits) that counts drop pulses, saturates at 16'hFFFF and clears on reset.
REQ-034 Without DOG_WR_OVF_CNT_EN, the ovf_cnt port and its counter SHALL be absent, and drop SHALL still be present.

Structure
REQ-035 The state encoding, the packed word width (24), the address width (21) and the tag-plus-data entry width (25) SHALL reside in a shared package, dog_pkg.
REQ-036 The FIFO SHALL be a single sub-module named dog_wr_fifo (depth parameter, full/empty flags, simultaneous push/pop).

Verification
REQ-037 Stimulus: wr_ready=1, 5 samples with diff0=1, diff1=-2, diff2=3. Required response: 5 words 24'h03FE01 at addresses 0..4, each 1 cycle after its input.
REQ-038 Stimulus: wr_ready=0 for 20 cycles with continuous in_en. Required response: 16 words held, 4 drop pulses, ovf_cnt=4 (macro defined), then in-order drain after wr_ready=1.
REQ-039 Stimulus: complete1 rises with 3 words still queued. Required response: those 3 words at addresses BASE0+k, and the next sample at 21'h100000.
REQ-040 Stimulus: complete2 rises, then 6 words drain with wr_ready toggling. Required response: done=1 only after the last handshake, with wr_data stable during stalls.
REQ-041 Stimulus: rst driven low while 8 words are queued. Required response: wr_valid=0 within the same cycle, state IDLE, and the next frame restarts at address 0.
